vdp_video_timing: RTL
=====================

# vdp_video_timing

Programmable raster timing generator for the VDP; next generation of the fixed-mode VGA timing block. Produces raster counters, sync, active-display and line/frame event strobes for any mode whose porch, sync and active sizes are written at run time. New mode settings are double-buffered and applied only at a frame boundary. A raster-line compare interrupt is provided for mid-frame effects.

## Interface
- X_WIDTH, 12: raster_x and horizontal config field width.
- Y_WIDTH, 11: raster_y and vertical config field width.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 848/16/112/112: reset-time horizontal sizes.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/6/8/23: reset-time vertical sizes.
- HSYNC_POL/VSYNC_POL, 0/0: reset-time sync polarity (1 = active-high).

- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hold_raster  in  1  freeze all raster state and registered outputs
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  X_WIDTH each  new horizontal sizes
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  Y_WIDTH each  new vertical sizes
- cfg_hsync_pol, cfg_vsync_pol  in  1  new polarities
- cfg_write  in  1  capture all cfg_* into pending set
- irq_line  in  Y_WIDTH  line compare value
- irq_line_en  in  1  enable line_irq
- raster_x  out  X_WIDTH  horizontal counter
- raster_y  out  Y_WIDTH  vertical counter
- hsync, vsync  out  1  sync at programmed polarity
- active_display  out  1  pixel in active area
- line_ended, frame_ended, active_line_started, active_frame_ended  out  1  single-cycle strobes
- line_irq  out  1  single-cycle line-compare strobe
- cfg_pending  out  1  pending set not yet applied
- cfg_error  out  1  single-cycle strobe: cfg_write rejected

## Operation
- Horizontal order per line: FP, SYNC, BP, ACTIVE; raster_x = 0 at first FP pixel; H_TOTAL = sum of four fields. Active x range: [fp+sync+bp, H_TOTAL-1].
- Vertical order per frame: ACTIVE, FP, SYNC, BP; raster_y = 0 at first active line; vertical state advances only on last pixel of a line.
- Each axis is a 2-bit phase FSM (FP→SYNC→BP→ACTIVE→FP for x; ACTIVE→FP→SYNC→BP→ACTIVE for y) advancing when the counter equals the running end-count of the current phase.
- Sync asserted (at polarity) for x in [fp, fp+sync-1] and y in [v_active+v_fp, v_active+v_fp+v_sync-1].
- cfg_write: if any size field is zero, ignore and pulse cfg_error next cycle; else latch to pending, set cfg_pending. A later write overwrites pending.
- Pending applied on the cycle the raster wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0); cfg_pending clears the same edge. Write coinciding with wrap cycle lands in pending, applies at next wrap.
- Active config never changes mid-frame.
- line_irq: pulses when raster_x becomes 0 and raster_y becomes irq_line, with irq_line_en high; irq_line ≥ V_TOTAL never fires.
- hold_raster high: counters, FSMs, strobes, config apply frozen; cfg_write still accepted into pending.

## Timing
- All outputs registered; strobes/sync/active_display describe the current raster_x/raster_y (computed from next-state, as in the existing block).
- line_ended high exactly when raster_x == 0; frame_ended when (0,0); active_line_started when raster_x == fp+sync+bp; active_frame_ended when raster_x == 0 and raster_y == v_active.
- Reset: raster_x=0, raster_y=0, x phase FP, y phase ACTIVE, active config = parameter defaults, pending cleared, all strobes 0, active_display 0, hsync/vsync at inactive level of default polarity.
- Reset mid-frame restarts at (0,0) next cycle, discards pending.
- Arithmetic: end-counts computed at X_WIDTH/Y_WIDTH; totals exceeding width are unsupported, not checked.

## Structure
- Package vdp_video_timing_pkg: phase encodings STATE_FP/SYNC/BP/ACTIVE, default mode constants.
- Sub-module vdp_timing_axis (counter + phase FSM + end-count), instantiated for x (advance every cycle) and y (advance on x line end).

## Test plan
- Default mode, two frames: H_TOTAL 1088, V_TOTAL 517; hsync low x 16..127; vsync low y 486..493; active_display only x ≥ 240, y < 480.
- Write 640x480 (16/96/48, 10/2/33) at y=100: cfg_pending=1; old timing until wrap; next frame H_TOTAL 800, V_TOTAL 525; cfg_pending 0 at (0,0).
- cfg_write with cfg_h_sync=0 -> cfg_error pulse, cfg_pending unchanged, timing unchanged.
- irq_line=200, en=1 -> line_irq one cycle at (0,200) each frame; en=0 -> none; irq_line=600 -> none.
- hold_raster 5 cycles at x=500 -> outputs constant, resume at x=501.
- Reset asserted at (300,300) with pending set -> (0,0), defaults restored, cfg_pending 0.

Source files
------------

// File: rtl/vdp_video_timing_pkg.sv
// Shared phase encodings, default mode constants and phase sequencing helper
// for the programmable VDP raster timing generator.
package vdp_video_timing_pkg;

    typedef enum logic [1:0] {
        STATE_FP     = 2'd0,
        STATE_SYNC   = 2'd1,
        STATE_BP     = 2'd2,
        STATE_ACTIVE = 2'd3
    } phase_t;

    localparam int unsigned DEF_X_WIDTH   = 32'd12;
    localparam int unsigned DEF_Y_WIDTH   = 32'd11;

    localparam int unsigned DEF_H_ACTIVE  = 32'd848;
    localparam int unsigned DEF_H_FP      = 32'd16;
    localparam int unsigned DEF_H_SYNC    = 32'd112;
    localparam int unsigned DEF_H_BP      = 32'd112;

    localparam int unsigned DEF_V_ACTIVE  = 32'd480;
    localparam int unsigned DEF_V_FP      = 32'd6;
    localparam int unsigned DEF_V_SYNC    = 32'd8;
    localparam int unsigned DEF_V_BP      = 32'd23;

    localparam bit          DEF_HSYNC_POL = 1'b0;
    localparam bit          DEF_VSYNC_POL = 1'b0;

    // Both axes walk the same cyclic order; they differ only in start phase.
    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            STATE_FP:     n = STATE_SYNC;
            STATE_SYNC:   n = STATE_BP;
            STATE_BP:     n = STATE_ACTIVE;
            STATE_ACTIVE: n = STATE_FP;
            default:      n = STATE_FP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vdp_video_timing_if.sv
// Configuration and raster status bundle of the VDP timing generator.
// The master side programs the mode; the slave side is the timing block.
interface vdp_video_timing_if
    import vdp_video_timing_pkg::*;
#(
    parameter int unsigned X_WIDTH = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH = DEF_Y_WIDTH
);
    logic               hold_raster;
    logic [X_WIDTH-1:0] cfg_h_active;
    logic [X_WIDTH-1:0] cfg_h_fp;
    logic [X_WIDTH-1:0] cfg_h_sync;
    logic [X_WIDTH-1:0] cfg_h_bp;
    logic [Y_WIDTH-1:0] cfg_v_active;
    logic [Y_WIDTH-1:0] cfg_v_fp;
    logic [Y_WIDTH-1:0] cfg_v_sync;
    logic [Y_WIDTH-1:0] cfg_v_bp;
    logic               cfg_hsync_pol;
    logic               cfg_vsync_pol;
    logic               cfg_write;
    logic [Y_WIDTH-1:0] irq_line;
    logic               irq_line_en;

    logic [X_WIDTH-1:0] raster_x;
    logic [Y_WIDTH-1:0] raster_y;
    logic               hsync;
    logic               vsync;
    logic               active_display;
    logic               line_ended;
    logic               frame_ended;
    logic               active_line_started;
    logic               active_frame_ended;
    logic               line_irq;
    logic               cfg_pending;
    logic               cfg_error;

    modport master (
        output hold_raster, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
               cfg_hsync_pol, cfg_vsync_pol, cfg_write, irq_line, irq_line_en,
        input  raster_x, raster_y, hsync, vsync, active_display, line_ended,
               frame_ended, active_line_started, active_frame_ended, line_irq,
               cfg_pending, cfg_error
    );

    modport slave (
        input  hold_raster, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
               cfg_hsync_pol, cfg_vsync_pol, cfg_write, irq_line, irq_line_en,
        output raster_x, raster_y, hsync, vsync, active_display, line_ended,
               frame_ended, active_line_started, active_frame_ended, line_irq,
               cfg_pending, cfg_error
    );

endinterface

// File: rtl/vdp_timing_axis.sv
// One raster axis: position counter plus a four-phase FSM tracking the running
// end-count of the current phase. Next-state values are exported for the top.
module vdp_timing_axis
    import vdp_video_timing_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_X_WIDTH,
    parameter phase_t      FIRST_PHASE = STATE_FP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [WIDTH-1:0] size_fp,
    input  logic [WIDTH-1:0] size_sync,
    input  logic [WIDTH-1:0] size_bp,
    input  logic [WIDTH-1:0] size_active,
    output logic [WIDTH-1:0] cnt_r,
    output logic [WIDTH-1:0] cnt_nxt_s,
    output phase_t           phase_nxt_s,
    output logic             last_s
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    phase_t           phase_r;
    phase_t           phase_after_s;
    logic [WIDTH-1:0] end_r;
    logic [WIDTH-1:0] end_nxt_s;
    logic [WIDTH-1:0] after_size_s;
    logic [WIDTH-1:0] first_size_s;
    logic             at_end_s;

    // Size of the phase about to be entered and of the phase entered on reset.
    always_comb begin
        phase_after_s = next_phase(phase_r);
        case (phase_after_s)
            STATE_FP:     after_size_s = size_fp;
            STATE_SYNC:   after_size_s = size_sync;
            STATE_BP:     after_size_s = size_bp;
            STATE_ACTIVE: after_size_s = size_active;
            default:      after_size_s = size_active;
        endcase
        case (FIRST_PHASE)
            STATE_FP:     first_size_s = size_fp;
            STATE_SYNC:   first_size_s = size_sync;
            STATE_BP:     first_size_s = size_bp;
            STATE_ACTIVE: first_size_s = size_active;
            default:      first_size_s = size_fp;
        endcase
    end

    // Advance: end-count grows by the entered phase size; leaving the last phase wraps to zero.
    always_comb begin
        at_end_s    = (cnt_r == end_r);
        last_s      = at_end_s && (phase_after_s == FIRST_PHASE);
        cnt_nxt_s   = cnt_r;
        phase_nxt_s = phase_r;
        end_nxt_s   = end_r;
        if (step && at_end_s) begin
            phase_nxt_s = phase_after_s;
            if (last_s) begin
                cnt_nxt_s = {WIDTH{1'b0}};
                end_nxt_s = after_size_s - ONE;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
                end_nxt_s = end_r + after_size_s;
            end
        end else if (step) begin
            cnt_nxt_s = cnt_r + ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Axis state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {WIDTH{1'b0}};
            phase_r <= FIRST_PHASE;
            end_r   <= first_size_s - ONE;
        end else begin
            cnt_r   <= cnt_nxt_s;
            phase_r <= phase_nxt_s;
            end_r   <= end_nxt_s;
        end
    end

endmodule

// File: rtl/vdp_video_timing.sv
// Programmable raster timing generator: double-buffered mode registers applied
// at frame wrap, two timing axes, and registered sync/active/event outputs.
module vdp_video_timing
    import vdp_video_timing_pkg::*;
#(
    parameter int unsigned X_WIDTH   = DEF_X_WIDTH,
    parameter int unsigned Y_WIDTH   = DEF_Y_WIDTH,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          HSYNC_POL = DEF_HSYNC_POL,
    parameter bit          VSYNC_POL = DEF_VSYNC_POL
) (
    input logic               clk,
    input logic               reset,
    vdp_video_timing_if.slave vt
);

    typedef struct packed {
        logic [X_WIDTH-1:0] h_active;
        logic [X_WIDTH-1:0] h_fp;
        logic [X_WIDTH-1:0] h_sync;
        logic [X_WIDTH-1:0] h_bp;
        logic [Y_WIDTH-1:0] v_active;
        logic [Y_WIDTH-1:0] v_fp;
        logic [Y_WIDTH-1:0] v_sync;
        logic [Y_WIDTH-1:0] v_bp;
        logic               hsync_pol;
        logic               vsync_pol;
    } mode_t;

    localparam mode_t DEFAULT_MODE = '{
        h_active:  X_WIDTH'(H_ACTIVE),
        h_fp:      X_WIDTH'(H_FP),
        h_sync:    X_WIDTH'(H_SYNC),
        h_bp:      X_WIDTH'(H_BP),
        v_active:  Y_WIDTH'(V_ACTIVE),
        v_fp:      Y_WIDTH'(V_FP),
        v_sync:    Y_WIDTH'(V_SYNC),
        v_bp:      Y_WIDTH'(V_BP),
        hsync_pol: HSYNC_POL,
        vsync_pol: VSYNC_POL
    };

    mode_t              mode_active_r;
    mode_t              mode_pending_r;
    mode_t              mode_next_s;
    mode_t              cfg_in_s;
    logic               cfg_pending_r;
    logic               cfg_error_r;
    logic               cfg_bad_s;

    logic               x_step_s;
    logic               y_step_s;
    logic               frame_wrap_s;
    logic               apply_s;
    logic [X_WIDTH-1:0] x_cnt_r;
    logic [X_WIDTH-1:0] x_cnt_nxt_s;
    logic [Y_WIDTH-1:0] y_cnt_r;
    logic [Y_WIDTH-1:0] y_cnt_nxt_s;
    phase_t             x_phase_nxt_s;
    phase_t             y_phase_nxt_s;
    logic               x_last_s;
    logic               y_last_s;
    logic [X_WIDTH-1:0] h_start_s;

    logic               hsync_r;
    logic               vsync_r;
    logic               active_display_r;
    logic               line_ended_r;
    logic               frame_ended_r;
    logic               active_line_started_r;
    logic               active_frame_ended_r;
    logic               line_irq_r;

    // Capture the programming bus and reject any mode containing a zero-sized phase.
    always_comb begin
        cfg_in_s = '{
            h_active:  vt.cfg_h_active,
            h_fp:      vt.cfg_h_fp,
            h_sync:    vt.cfg_h_sync,
            h_bp:      vt.cfg_h_bp,
            v_active:  vt.cfg_v_active,
            v_fp:      vt.cfg_v_fp,
            v_sync:    vt.cfg_v_sync,
            v_bp:      vt.cfg_v_bp,
            hsync_pol: vt.cfg_hsync_pol,
            vsync_pol: vt.cfg_vsync_pol
        };
        cfg_bad_s = (vt.cfg_h_active == {X_WIDTH{1'b0}}) || (vt.cfg_h_fp == {X_WIDTH{1'b0}}) ||
                    (vt.cfg_h_sync   == {X_WIDTH{1'b0}}) || (vt.cfg_h_bp == {X_WIDTH{1'b0}}) ||
                    (vt.cfg_v_active == {Y_WIDTH{1'b0}}) || (vt.cfg_v_fp == {Y_WIDTH{1'b0}}) ||
                    (vt.cfg_v_sync   == {Y_WIDTH{1'b0}}) || (vt.cfg_v_bp == {Y_WIDTH{1'b0}});
    end

    // Mode in force after this edge: the axes see the new mode on the wrap edge itself.
    always_comb begin
        x_step_s     = ~vt.hold_raster;
        y_step_s     = x_step_s & x_last_s;
        frame_wrap_s = y_step_s & y_last_s;
        apply_s      = frame_wrap_s & cfg_pending_r;
        if (reset) begin
            mode_next_s = DEFAULT_MODE;
        end else if (apply_s) begin
            mode_next_s = mode_pending_r;
        end else begin
            mode_next_s = mode_active_r;
        end
        h_start_s = mode_next_s.h_fp + mode_next_s.h_sync + mode_next_s.h_bp;
    end

    vdp_timing_axis #(
        .WIDTH       (X_WIDTH),
        .FIRST_PHASE (STATE_FP)
    ) u_axis_x (
        .clk         (clk),
        .reset       (reset),
        .step        (x_step_s),
        .size_fp     (mode_next_s.h_fp),
        .size_sync   (mode_next_s.h_sync),
        .size_bp     (mode_next_s.h_bp),
        .size_active (mode_next_s.h_active),
        .cnt_r       (x_cnt_r),
        .cnt_nxt_s   (x_cnt_nxt_s),
        .phase_nxt_s (x_phase_nxt_s),
        .last_s      (x_last_s)
    );

    vdp_timing_axis #(
        .WIDTH       (Y_WIDTH),
        .FIRST_PHASE (STATE_ACTIVE)
    ) u_axis_y (
        .clk         (clk),
        .reset       (reset),
        .step        (y_step_s),
        .size_fp     (mode_next_s.v_fp),
        .size_sync   (mode_next_s.v_sync),
        .size_bp     (mode_next_s.v_bp),
        .size_active (mode_next_s.v_active),
        .cnt_r       (y_cnt_r),
        .cnt_nxt_s   (y_cnt_nxt_s),
        .phase_nxt_s (y_phase_nxt_s),
        .last_s      (y_last_s)
    );

    // Active/pending mode registers; a write landing on the wrap edge stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_active_r  <= DEFAULT_MODE;
            mode_pending_r <= DEFAULT_MODE;
            cfg_pending_r  <= 1'b0;
            cfg_error_r    <= 1'b0;
        end else begin
            mode_active_r <= mode_next_s;
            cfg_error_r   <= vt.cfg_write & cfg_bad_s;
            if (vt.cfg_write && !cfg_bad_s) begin
                mode_pending_r <= cfg_in_s;
                cfg_pending_r  <= 1'b1;
            end else if (apply_s) begin
                cfg_pending_r  <= 1'b0;
            end else begin
                cfg_pending_r  <= cfg_pending_r;
            end
        end
    end

    // Registered raster outputs, derived from next-state so they align with raster_x/raster_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_r               <= ~HSYNC_POL;
            vsync_r               <= ~VSYNC_POL;
            active_display_r      <= 1'b0;
            line_ended_r          <= 1'b0;
            frame_ended_r         <= 1'b0;
            active_line_started_r <= 1'b0;
            active_frame_ended_r  <= 1'b0;
            line_irq_r            <= 1'b0;
        end else if (x_step_s) begin
            hsync_r               <= (x_phase_nxt_s == STATE_SYNC) ~^ mode_next_s.hsync_pol;
            vsync_r               <= (y_phase_nxt_s == STATE_SYNC) ~^ mode_next_s.vsync_pol;
            active_display_r      <= (x_phase_nxt_s == STATE_ACTIVE) && (y_phase_nxt_s == STATE_ACTIVE);
            line_ended_r          <= (x_cnt_nxt_s == {X_WIDTH{1'b0}});
            frame_ended_r         <= (x_cnt_nxt_s == {X_WIDTH{1'b0}}) && (y_cnt_nxt_s == {Y_WIDTH{1'b0}});
            active_line_started_r <= (x_cnt_nxt_s == h_start_s);
            active_frame_ended_r  <= (x_cnt_nxt_s == {X_WIDTH{1'b0}}) && (y_cnt_nxt_s == mode_next_s.v_active);
            line_irq_r            <= vt.irq_line_en && (x_cnt_nxt_s == {X_WIDTH{1'b0}}) &&
                                     (y_cnt_nxt_s == vt.irq_line);
        end else begin
            hsync_r               <= hsync_r;
            vsync_r               <= vsync_r;
            active_display_r      <= active_display_r;
            line_ended_r          <= line_ended_r;
            frame_ended_r         <= frame_ended_r;
            active_line_started_r <= active_line_started_r;
            active_frame_ended_r  <= active_frame_ended_r;
            line_irq_r            <= line_irq_r;
        end
    end

    assign vt.raster_x            = x_cnt_r;
    assign vt.raster_y            = y_cnt_r;
    assign vt.hsync               = hsync_r;
    assign vt.vsync               = vsync_r;
    assign vt.active_display      = active_display_r;
    assign vt.line_ended          = line_ended_r;
    assign vt.frame_ended         = frame_ended_r;
    assign vt.active_line_started = active_line_started_r;
    assign vt.active_frame_ended  = active_frame_ended_r;
    assign vt.line_irq            = line_irq_r;
    assign vt.cfg_pending         = cfg_pending_r;
    assign vt.cfg_error           = cfg_error_r;

endmodule
